value_adjuster: RTL and testbench

Front-panel value stepper that sits directly downstream of the button repeater. It takes the repeated "up" and "down" button levels and detects each rising edge, and on every edge it steps a bounded register value by one. It drives that value, plus a one-cycle change strobe, to the display/time-setting logic. A synchronous load port lets the owning logic preset the value, for example when entering a set mode.

---
 rtl/value_adjuster.sv | 63 ++++++
 tb/tb_value_adjuster.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/value_adjuster.sv
// value_adjuster: edge-triggered bounded up/down stepper with clamped preset; define VALUE_ADJUSTER_WRAP_EN to wrap at the limits instead of saturating
module value_adjuster #(
  parameter int WIDTH = 6,
  parameter int MIN = 0,
  parameter int MAX = 59,
  parameter int INIT = 0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_value,
  output logic             o_changed
);
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
`ifdef VALUE_ADJUSTER_WRAP_EN
  localparam logic [WIDTH-1:0] UP_LIMIT = MIN_V;
  localparam logic [WIDTH-1:0] DOWN_LIMIT = MAX_V;
`else
  localparam logic [WIDTH-1:0] UP_LIMIT = MAX_V;
  localparam logic [WIDTH-1:0] DOWN_LIMIT = MIN_V;
`endif
  logic [1:0] up_sync, down_sync;
  logic up_prev, down_prev, up_edge, down_edge;
  logic [WIDTH-1:0] load_clamped, up_value, down_value, next_value;
  // Synchronize each button and track its last level; preset high so a button held through reset needs a release first
  always_ff @(posedge i_clock)
    if (i_reset) begin
      up_sync <= '1;
      down_sync <= '1;
      up_prev <= 1'b1;
      down_prev <= 1'b1;
    end else begin
      up_sync <= {up_sync[0], i_up};
      down_sync <= {down_sync[0], i_down};
      up_prev <= up_sync[1];
      down_prev <= down_sync[1];
    end
  // Load beats stepping, simultaneous edges cancel, limits are checked before the step so it never overflows
  always_comb begin
    up_edge = up_sync[1] & ~up_prev;
    down_edge = down_sync[1] & ~down_prev;
    load_clamped = int'(i_load_value) < MIN ? MIN_V : int'(i_load_value) > MAX ? MAX_V : i_load_value;
    up_value = o_value == MAX_V ? UP_LIMIT : o_value + 1'b1;
    down_value = o_value == MIN_V ? DOWN_LIMIT : o_value - 1'b1;
    next_value = i_load ? load_clamped :
                 up_edge & ~down_edge ? up_value :
                 down_edge & ~up_edge ? down_value : o_value;
  end
  // Value register with a one-cycle strobe whenever it actually moves
  always_ff @(posedge i_clock)
    if (i_reset) begin
      o_value <= INIT_V;
      o_changed <= 1'b0;
    end else begin
      o_value <= next_value;
      o_changed <= next_value != o_value;
    end
endmodule

// File: tb/tb_value_adjuster.sv
// tb_value_adjuster: scoreboard bench for value_adjuster with INIT=30
module tb_value_adjuster;
`ifdef VALUE_ADJUSTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up = 1'b0;
  logic down = 1'b0;
  logic load = 1'b0;
  logic [5:0] load_value = '0;
  logic [5:0] value;
  logic changed;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_cyc[$];
  logic [5:0] exp_val[$];

  value_adjuster #(.WIDTH(6), .MIN(0), .MAX(59), .INIT(30)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_up(up),
    .i_down(down),
    .i_load(load),
    .i_load_value(load_value),
    .o_value(value),
    .o_changed(changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change strobe must match the next expected value and cycle
  always @(negedge clk) begin
    if (changed) begin
      vectors++;
      if (exp_val.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: cycle %0d value %0d, no change expected", cyc, value);
      end else begin
        int ec;
        logic [5:0] ev;
        ec = exp_cyc.pop_front();
        ev = exp_val.pop_front();
        if (ec != cyc || ev != value) begin
          miscompares++;
          $display("FAIL change: got value %0d at cycle %0d, expected %0d at cycle %0d", value, cyc, ev, ec);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic expect_change(input int dly, input logic [5:0] v);
    exp_cyc.push_back(cyc + dly);
    exp_val.push_back(v);
  endtask

  task automatic pulse_up();
    up = 1'b1;
    tick(4);
    up = 1'b0;
    tick(4);
  endtask

  task automatic pulse_down();
    down = 1'b1;
    tick(4);
    down = 1'b0;
    tick(4);
  endtask

  task automatic do_load(input logic [5:0] v, input bit moves, input logic [5:0] ev);
    if (moves) expect_change(1, ev);
    load = 1'b1;
    load_value = v;
    tick(1);
    load = 1'b0;
    tick(3);
  endtask

  initial begin
    tick(2);
    check("reset_value", value, 30);
    check("reset_changed", changed, 0);
    rst = 1'b0;
    tick(4);
    for (int i = 31; i <= 33; i++) begin
      expect_change(3, 6'(i));
      pulse_up();
    end
    check("three_ups", value, 33);
    up = 1'b1;
    rst = 1'b1;
    tick(2);
    check("reset_held_value", value, 30);
    rst = 1'b0;
    tick(10);
    up = 1'b0;
    tick(4);
    check("held_through_reset", value, 30);
    expect_change(3, 6'd31);
    pulse_up();
    check("up_after_release", value, 31);
    do_load(6'd59, 1'b1, 6'd59);
    check("load_max", value, 59);
    if (WRAP) expect_change(3, 6'd0);
    pulse_up();
    check("up_at_max", value, WRAP ? 0 : 59);
    do_load(6'd0, !WRAP, 6'd0);
    check("load_min", value, 0);
    if (WRAP) expect_change(3, 6'd59);
    pulse_down();
    check("down_at_min", value, WRAP ? 59 : 0);
    do_load(6'd10, 1'b1, 6'd10);
    up = 1'b1;
    down = 1'b1;
    tick(4);
    up = 1'b0;
    down = 1'b0;
    tick(4);
    check("up_down_cancel", value, 10);
    do_load(6'd5, 1'b1, 6'd5);
    up = 1'b1;
    tick(2);
    expect_change(1, 6'd59);
    load = 1'b1;
    load_value = 6'd63;
    tick(1);
    load = 1'b0;
    check("load_clamp_changed", changed, 1);
    tick(2);
    up = 1'b0;
    tick(4);
    check("load_clamp_value", value, 59);
    do_load(6'd2, 1'b1, 6'd2);
    check("load_two", value, 2);
    do_load(6'd20, 1'b1, 6'd20);
    down = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    check("reset_mid_value", value, 30);
    check("reset_mid_changed", changed, 0);
    rst = 1'b0;
    down = 1'b0;
    tick(6);
    check("after_mid_reset", value, 30);
    check("scoreboard_drained", exp_val.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
